// File: rtl/jtopl_timers.sv
// jtopl_timers -- OPL Timer A / Timer B block.
// Turns the timer controls coming from the register interface into status
// flags, the interrupt line and the Timer A overflow strobe used for CSM key-on.
// Every piece of state advances only on cenop.
//
// Ports:
//   clk          system clock
//   rst          asynchronous reset, active-high
//   cenop        operator clock enable
//   value_A/B    8-bit reload values
//   load_A/B     1 = timer running, 0 = stopped (rising edge reloads)
//   flagen_A/B   1 = overflow may set the matching flag
//   clr_flag_A/B clear the matching flag (sampled with cenop)
//   flag_A/B     registered overflow flags
//   overflow_A   registered strobe, one cenop period per Timer A overflow
//   irq_n        active-low interrupt, ~(flag_A | flag_B)
//   status       {~irq_n, flag_A, flag_B, 5'd0}
module jtopl_timers #(
  parameter int PRE_A = 72,
  parameter int MUL_B = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cenop,
  input  logic [7:0] value_A,
  input  logic [7:0] value_B,
  input  logic       load_A,
  input  logic       load_B,
  input  logic       flagen_A,
  input  logic       flagen_B,
  input  logic       clr_flag_A,
  input  logic       clr_flag_B,
  output logic       flag_A,
  output logic       flag_B,
  output logic       overflow_A,
  output logic       irq_n,
  output logic [7:0] status
);

  localparam int PW = (PRE_A > 1) ? $clog2(PRE_A) : 1;
  localparam int MW = (MUL_B > 1) ? $clog2(MUL_B) : 1;

  logic [PW-1:0] pre_q, pre_d;
  logic [MW-1:0] mul_q, mul_d;
  logic [7:0]    cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic          load_a_q, load_a_d, load_b_q, load_b_d;
  logic          flag_a_q, flag_a_d, flag_b_q, flag_b_d;
  logic          ovf_a_q, ovf_a_d;
  logic          tick_a, tick_b, ovf_a, ovf_b;

  // Free-running prescalers: never restarted by load, so the first tick after
  // a timer starts lands anywhere within one prescaler period.
  always_comb begin
    pre_d  = pre_q;
    mul_d  = mul_q;
    tick_a = 1'b0;
    tick_b = 1'b0;
    if (cenop) begin
      if (pre_q == PW'(PRE_A - 1)) begin
        pre_d  = '0;
        tick_a = 1'b1;
      end else begin
        pre_d = pre_q + PW'(1);
      end
      if (tick_a) begin
        if (mul_q == MW'(MUL_B - 1)) begin
          mul_d  = '0;
          tick_b = 1'b1;
        end else begin
          mul_d = mul_q + MW'(1);
        end
      end
    end
  end

  // Counters: a load rising edge reloads and swallows any tick that cenop.
  always_comb begin
    cnt_a_d  = cnt_a_q;
    cnt_b_d  = cnt_b_q;
    ovf_a    = 1'b0;
    ovf_b    = 1'b0;
    load_a_d = load_a_q;
    load_b_d = load_b_q;
    if (cenop) begin
      load_a_d = load_A;
      load_b_d = load_B;
      if (load_A && !load_a_q) begin
        cnt_a_d = value_A;
      end else if (load_A && tick_a) begin
        if (cnt_a_q == 8'hFF) begin
          ovf_a   = 1'b1;
          cnt_a_d = value_A;
        end else begin
          cnt_a_d = cnt_a_q + 8'd1;
        end
      end
      if (load_B && !load_b_q) begin
        cnt_b_d = value_B;
      end else if (load_B && tick_b) begin
        if (cnt_b_q == 8'hFF) begin
          ovf_b   = 1'b1;
          cnt_b_d = value_B;
        end else begin
          cnt_b_d = cnt_b_q + 8'd1;
        end
      end
    end
  end

  // Flags: a qualifying overflow beats a simultaneous clear so no event is lost.
  always_comb begin
    flag_a_d = flag_a_q;
    flag_b_d = flag_b_q;
    ovf_a_d  = ovf_a_q;
    if (cenop) begin
      ovf_a_d = ovf_a;
      if (ovf_a && flagen_A)   flag_a_d = 1'b1;
      else if (clr_flag_A)     flag_a_d = 1'b0;
      if (ovf_b && flagen_B)   flag_b_d = 1'b1;
      else if (clr_flag_B)     flag_b_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q    <= '0;
      mul_q    <= '0;
      cnt_a_q  <= 8'd0;
      cnt_b_q  <= 8'd0;
      load_a_q <= 1'b0;
      load_b_q <= 1'b0;
      flag_a_q <= 1'b0;
      flag_b_q <= 1'b0;
      ovf_a_q  <= 1'b0;
    end else begin
      pre_q    <= pre_d;
      mul_q    <= mul_d;
      cnt_a_q  <= cnt_a_d;
      cnt_b_q  <= cnt_b_d;
      load_a_q <= load_a_d;
      load_b_q <= load_b_d;
      flag_a_q <= flag_a_d;
      flag_b_q <= flag_b_d;
      ovf_a_q  <= ovf_a_d;
    end
  end

  assign flag_A     = flag_a_q;
  assign flag_B     = flag_b_q;
  assign overflow_A = ovf_a_q;
  assign irq_n      = ~(flag_a_q | flag_b_q);
  assign status     = {~irq_n, flag_a_q, flag_b_q, 5'd0};

endmodule

// File: tb/tb_jtopl_timers.sv
module tb_jtopl_timers;

  localparam int PRE = 4;
  localparam int MUL = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cenop = 1'b0;
  logic [7:0] value_A = 8'h00, value_B = 8'h00;
  logic       load_A = 1'b0, load_B = 1'b0;
  logic       flagen_A = 1'b0, flagen_B = 1'b0;
  logic       clr_flag_A = 1'b0, clr_flag_B = 1'b0;
  logic       flag_A, flag_B, overflow_A, irq_n;
  logic [7:0] status;

  jtopl_timers #(.PRE_A(PRE), .MUL_B(MUL)) dut (
    .clk(clk), .rst(rst), .cenop(cenop),
    .value_A(value_A), .value_B(value_B),
    .load_A(load_A), .load_B(load_B),
    .flagen_A(flagen_A), .flagen_B(flagen_B),
    .clr_flag_A(clr_flag_A), .clr_flag_B(clr_flag_B),
    .flag_A(flag_A), .flag_B(flag_B), .overflow_A(overflow_A),
    .irq_n(irq_n), .status(status)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         n;
    bit         cen, ldA, ldB, feA, feB, clrA, clrB;
    logic [7:0] vA, vB;
    bit         eA, eB, eOv;
    logic [7:0] eSt;
  } vec_t;

  typedef struct {
    logic       fA, fB, ov, irqn;
    logic [7:0] st;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // reference model state: cenops counted since reset locate the prescaler ticks
  int         ncen;
  logic [7:0] m_cntA, m_cntB;
  bit         m_lastA, m_lastB, m_fA, m_fB, m_ov;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    ncen = 0; m_cntA = 0; m_cntB = 0;
    m_lastA = 0; m_lastB = 0; m_fA = 0; m_fB = 0; m_ov = 0;
  endtask

  task automatic model(input vec_t v);
    bit tA, tB, oA, oB;
    if (!v.cen) return;
    ncen++;
    tA = (ncen % PRE) == 0;
    tB = (ncen % (PRE * MUL)) == 0;
    oA = 0; oB = 0;
    if (v.ldA && !m_lastA) m_cntA = v.vA;
    else if (v.ldA && tA) begin
      if (m_cntA == 8'hFF) begin oA = 1; m_cntA = v.vA; end
      else m_cntA = m_cntA + 8'd1;
    end
    if (v.ldB && !m_lastB) m_cntB = v.vB;
    else if (v.ldB && tB) begin
      if (m_cntB == 8'hFF) begin oB = 1; m_cntB = v.vB; end
      else m_cntB = m_cntB + 8'd1;
    end
    if (oA && v.feA) m_fA = 1; else if (v.clrA) m_fA = 0;
    if (oB && v.feB) m_fB = 1; else if (v.clrB) m_fB = 0;
    m_ov = oA;
    m_lastA = v.ldA;
    m_lastB = v.ldB;
  endtask

  // one clock: drive, predict, push; then sample after the edge and pop
  task automatic step(input vec_t v);
    exp_t e;
    cenop = v.cen; load_A = v.ldA; load_B = v.ldB;
    flagen_A = v.feA; flagen_B = v.feB;
    clr_flag_A = v.clrA; clr_flag_B = v.clrB;
    value_A = v.vA; value_B = v.vB;
    model(v);
    e.fA = m_fA; e.fB = m_fB; e.ov = m_ov; e.irqn = ~(m_fA | m_fB);
    e.st = {m_fA | m_fB, m_fA, m_fB, 5'd0};
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("sb flag_A", {7'd0, flag_A}, {7'd0, e.fA});
    chk("sb flag_B", {7'd0, flag_B}, {7'd0, e.fB});
    chk("sb overflow_A", {7'd0, overflow_A}, {7'd0, e.ov});
    chk("sb irq_n", {7'd0, irq_n}, {7'd0, e.irqn});
    chk("sb status", status, e.st);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " flag_A"}, {7'd0, flag_A}, 8'd0);
    chk({tag, " flag_B"}, {7'd0, flag_B}, 8'd0);
    chk({tag, " overflow_A"}, {7'd0, overflow_A}, 8'd0);
    chk({tag, " irq_n"}, {7'd0, irq_n}, 8'd1);
    chk({tag, " status"}, status, 8'h00);
  endtask

  vec_t vecs[24];
  vec_t r;

  initial begin
    //          n   cen ldA ldB feA feB clrA clrB vA     vB     eA eB eOv eSt
    vecs[0]  = '{3,  1, 0, 0, 1, 0, 0, 0, 8'hFE, 8'hFF, 0, 0, 0, 8'h00};
    vecs[1]  = '{1,  1, 1, 0, 1, 0, 0, 0, 8'hFE, 8'hFF, 0, 0, 0, 8'h00};
    vecs[2]  = '{4,  1, 1, 0, 1, 0, 0, 0, 8'hFE, 8'hFF, 0, 0, 0, 8'h00};
    vecs[3]  = '{3,  1, 1, 0, 1, 0, 0, 0, 8'hFE, 8'hFF, 0, 0, 0, 8'h00};
    vecs[4]  = '{1,  1, 1, 0, 1, 0, 0, 0, 8'hFE, 8'hFF, 1, 0, 1, 8'hC0};
    vecs[5]  = '{1,  1, 1, 0, 1, 0, 0, 0, 8'hFE, 8'hFF, 1, 0, 0, 8'hC0};
    vecs[6]  = '{1,  1, 1, 0, 1, 0, 1, 0, 8'hFE, 8'hFF, 0, 0, 0, 8'h00};
    vecs[7]  = '{5,  1, 1, 0, 1, 0, 0, 0, 8'hFE, 8'hFF, 0, 0, 0, 8'h00};
    vecs[8]  = '{1,  1, 1, 0, 1, 0, 1, 0, 8'hFE, 8'hFF, 1, 0, 1, 8'hC0};
    vecs[9]  = '{5,  0, 1, 0, 1, 0, 1, 0, 8'hFE, 8'hFF, 1, 0, 1, 8'hC0};
    vecs[10] = '{1,  1, 1, 0, 1, 0, 1, 0, 8'hFE, 8'hFF, 0, 0, 0, 8'h00};
    vecs[11] = '{1,  1, 1, 1, 0, 1, 0, 0, 8'hFE, 8'hFF, 0, 0, 0, 8'h00};
    vecs[12] = '{9,  1, 1, 1, 0, 1, 0, 0, 8'hFE, 8'hFF, 0, 0, 0, 8'h00};
    vecs[13] = '{1,  1, 1, 1, 0, 1, 0, 0, 8'hFE, 8'hFF, 0, 1, 0, 8'hA0};
    vecs[14] = '{4,  1, 1, 1, 0, 1, 0, 0, 8'hFE, 8'hFF, 0, 1, 1, 8'hA0};
    vecs[15] = '{4,  1, 1, 1, 0, 1, 0, 0, 8'hFF, 8'hFF, 0, 1, 0, 8'hA0};
    vecs[16] = '{4,  1, 1, 1, 0, 1, 0, 0, 8'hFF, 8'hFF, 0, 1, 1, 8'hA0};
    vecs[17] = '{4,  1, 1, 1, 0, 1, 0, 0, 8'hFF, 8'hFF, 0, 1, 1, 8'hA0};
    vecs[18] = '{1,  1, 0, 0, 0, 0, 0, 1, 8'hF0, 8'hFF, 0, 0, 0, 8'h00};
    vecs[19] = '{1,  1, 1, 0, 0, 0, 0, 0, 8'hF0, 8'hFF, 0, 0, 0, 8'h00};
    vecs[20] = '{11, 1, 1, 0, 0, 0, 0, 0, 8'hF0, 8'hFF, 0, 0, 0, 8'h00};
    vecs[21] = '{20, 1, 0, 0, 0, 0, 0, 0, 8'hF0, 8'hFF, 0, 0, 0, 8'h00};
    vecs[22] = '{1,  1, 1, 0, 1, 0, 0, 0, 8'hFE, 8'hFF, 0, 0, 0, 8'h00};
    vecs[23] = '{9,  1, 1, 0, 1, 0, 0, 0, 8'hFE, 8'hFF, 1, 0, 0, 8'hC0};

    model_clear();
    repeat (3) @(posedge clk);
    #1;
    chk_reset_state("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 24; i++) begin
      for (int k = 0; k < vecs[i].n; k++) step(vecs[i]);
      chk($sformatf("vec%0d flag_A", i), {7'd0, flag_A}, {7'd0, vecs[i].eA});
      chk($sformatf("vec%0d flag_B", i), {7'd0, flag_B}, {7'd0, vecs[i].eB});
      chk($sformatf("vec%0d overflow_A", i), {7'd0, overflow_A}, {7'd0, vecs[i].eOv});
      chk($sformatf("vec%0d status", i), status, vecs[i].eSt);
    end

    // asynchronous reset between clock edges while flag_A is set
    #2;
    rst = 1'b1;
    #1;
    chk_reset_state("async reset");
    model_clear();
    @(negedge clk);
    rst = 1'b0;

    // randomized traffic checked by the scoreboard only
    r = vecs[0];
    r.n = 1;
    r.feA = 1; r.feB = 1;
    for (int i = 0; i < 400; i++) begin
      r.cen  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 24) == 0) r.ldA = ~r.ldA;
      if ($urandom_range(0, 24) == 0) r.ldB = ~r.ldB;
      if ($urandom_range(0, 31) == 0) r.feA = ~r.feA;
      if ($urandom_range(0, 31) == 0) r.feB = ~r.feB;
      r.clrA = ($urandom_range(0, 9) == 0);
      r.clrB = ($urandom_range(0, 9) == 0);
      r.vA   = 8'(8'hF8 + $urandom_range(0, 7));
      r.vB   = 8'(8'hFC + $urandom_range(0, 3));
      step(r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
